count_lane_unpacker: RTL and testbench

//  Receive side of the packed count-word interface: accepts one packed array of LANES
//  bit_int_t words per valid/ready beat. Emits each lane as a count_t, one per cycle,

---
 rtl/count_pkg.sv | 25 ++
 rtl/count_lane_select.sv | 36 +++
 rtl/count_lane_unpacker.sv | 130 +++++++++++++
 tb/tb_count_lane_unpacker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared types and constants for the packed count-word interface.
package count_pkg;

    typedef logic [15:0] count_t;
    typedef bit   [31:0] bit_int_t;

    localparam int COUNT_LANES = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpack_state_e;

    // Width of a lane index; a single-lane interface still carries one bit.
    function automatic int lane_idx_w(input int lanes);
        int w;
        if (lanes > 1) begin
            w = $clog2(lanes);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/count_lane_select.sv
// Combinational lane picker: selects one packed word and narrows it to a count.
module count_lane_select
    import count_pkg::*;
#(
    parameter int LANES   = COUNT_LANES,
    parameter int WORD_W  = $bits(bit_int_t),
    parameter int COUNT_W = $bits(count_t),
    parameter int LANE_W  = lane_idx_w(LANES)
) (
    input  logic [LANES*WORD_W-1:0] hold_i,
    input  logic [LANE_W-1:0]       lane_i,
    output logic [COUNT_W-1:0]      count_o,
    output logic                    trunc_o
);

    logic [WORD_W-1:0] word_s;

    // AND-OR mux over the lanes; an index past LANES-1 yields zero.
    always_comb begin
        word_s = '0;
        for (int i = 0; i < LANES; i++) begin
            word_s = word_s | (hold_i[i*WORD_W +: WORD_W] & {WORD_W{lane_i == LANE_W'(i)}});
        end
    end

    assign count_o = word_s[COUNT_W-1:0];

    generate
        if (COUNT_W < WORD_W) begin : g_trunc
            assign trunc_o = |word_s[WORD_W-1:COUNT_W];
        end else begin : g_fit
            assign trunc_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/count_lane_unpacker.sv
// Unpacks a beat of LANES packed words into one count per cycle, lane 0 first.
module count_lane_unpacker
    import count_pkg::*;
#(
    parameter int LANES   = COUNT_LANES,
    parameter int WORD_W  = $bits(bit_int_t),
    parameter int COUNT_W = $bits(count_t),
    parameter int LANE_W  = lane_idx_w(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*WORD_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COUNT_W-1:0]      out_count,
    output logic [LANE_W-1:0]       out_lane,
    output logic                    out_last,
    output logic                    out_trunc,
    output logic                    err_sticky,
    output logic [15:0]             beat_cnt
);

    unpack_state_e             state_q, state_d;
    logic [LANES*WORD_W-1:0]   hold_q, hold_d;
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [15:0]               beat_cnt_q, beat_cnt_d;
    logic                      err_q, err_d;

    logic                      lane_last_s;
    logic                      lane_trunc_s;
    logic [COUNT_W-1:0]        lane_count_s;
    logic                      accept_s;
    logic                      take_s;

    count_lane_select #(
        .LANES   (LANES),
        .WORD_W  (WORD_W),
        .COUNT_W (COUNT_W),
        .LANE_W  (LANE_W)
    ) u_select (
        .hold_i  (hold_q),
        .lane_i  (lane_q),
        .count_o (lane_count_s),
        .trunc_o (lane_trunc_s)
    );

    assign lane_last_s = (lane_q == LANE_W'(LANES - 1));
    assign out_valid   = (state_q == EMIT);
    assign out_count   = lane_count_s;
    assign out_lane    = lane_q;
    assign out_last    = out_valid & lane_last_s;
    assign out_trunc   = out_valid & lane_trunc_s;
    assign err_sticky  = err_q;
    assign beat_cnt    = beat_cnt_q;
    assign accept_s    = in_valid & in_ready;
    assign take_s      = out_valid & out_ready;

    // Ready: always free when idle, otherwise only as the final lane leaves.
    always_comb begin
        if (rst) begin
            in_ready = 1'b0;
        end else if (state_q == IDLE) begin
            in_ready = 1'b1;
        end else begin
            in_ready = out_ready & lane_last_s;
        end
    end

    // Next-state: capture beats, step lanes, chain beats without a bubble.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        lane_d     = lane_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q | (take_s & lane_trunc_s);
        if (accept_s) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    hold_d  = in_data;
                    lane_d  = '0;
                    state_d = EMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (take_s && !lane_last_s) begin
                    lane_d = lane_q + LANE_W'(1);
                end else if (take_s && accept_s) begin
                    hold_d  = in_data;
                    lane_d  = '0;
                    state_d = EMIT;
                end else if (take_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            lane_q     <= '0;
            beat_cnt_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            lane_q     <= lane_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_count_lane_unpacker.sv
// Bench: queue-based lane model checked every cycle, plus directed literal checks.
module tb_count_lane_unpacker;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [63:0] in_data;
    logic        in_ready, out_valid, out_last, out_trunc, err_sticky;
    logic [15:0] out_count, beat_cnt;
    logic [0:0]  out_lane;

    logic        rst2, in_valid2, out_ready2;
    logic [31:0] in_data2;
    logic        in_ready2, out_valid2, out_last2, out_trunc2, err_sticky2;
    logic [15:0] out_count2, beat_cnt2;
    logic [0:0]  out_lane2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] cnt;
        int          lane;
        bit          last;
        bit          trunc;
    } lane_t;

    lane_t       mq[$];
    logic [15:0] m_beat = 16'd0;
    bit          m_err  = 1'b0;
    bit          m_rdy;
    bit          saw9   = 1'b0;
    logic [15:0] pat;

    always #5 clk = ~clk;

    count_lane_unpacker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_lane(out_lane),
        .out_last(out_last), .out_trunc(out_trunc), .err_sticky(err_sticky), .beat_cnt(beat_cnt)
    );

    count_lane_unpacker #(.LANES(1)) dut1l (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_count(out_count2), .out_lane(out_lane2),
        .out_last(out_last2), .out_trunc(out_trunc2), .err_sticky(err_sticky2), .beat_cnt(beat_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: the queue holds the lanes still owed to the consumer, front first.
    always @(posedge clk) begin
        lane_t e;
        logic [31:0] w;
        m_rdy = !rst && (mq.size() == 0 || (mq.size() == 1 && out_ready));
        if (rst) begin
            mq.delete();
            m_beat = 16'd0;
            m_err  = 1'b0;
        end else begin
            if (mq.size() > 0 && out_ready) begin
                if (mq[0].trunc) m_err = 1'b1;
                void'(mq.pop_front());
            end
            if (in_valid && m_rdy) begin
                for (int i = 0; i < 2; i++) begin
                    w       = in_data[i*32 +: 32];
                    e.cnt   = w[15:0];
                    e.lane  = i;
                    e.last  = (i == 1);
                    e.trunc = (w >> 16) != 32'd0;
                    mq.push_back(e);
                end
                m_beat = m_beat + 16'd1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready),
                32'(mq.size() == 0 || (mq.size() == 1 && out_ready)));
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("out_count", 32'(out_count), 32'(mq[0].cnt));
                chk("out_lane",  32'(out_lane),  32'(mq[0].lane));
                chk("out_last",  32'(out_last),  32'(mq[0].last));
                chk("out_trunc", 32'(out_trunc), 32'(mq[0].trunc));
                if (out_count == 16'd9) saw9 = 1'b1;
            end else begin
                chk("idle_last",  32'(out_last),  32'd0);
                chk("idle_trunc", 32'(out_trunc), 32'd0);
            end
            chk("beat_cnt",   32'(beat_cnt),   32'(m_beat));
            chk("err_sticky", 32'(err_sticky), 32'(m_err));
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = 64'd0;
        rst2 = 1'b1; in_valid2 = 1'b0; out_ready2 = 1'b1; in_data2 = 32'd0;

        // 1: reset for 3 cycles, with a beat offered during reset that must be dropped
        step(); step();
        in_valid = 1'b1; in_data = {32'd7, 32'd7};
        step();
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("t1_out_valid", 32'(out_valid), 32'd0);
        chk("t1_in_ready",  32'(in_ready),  32'd1);
        chk("t1_beat_cnt",  32'(beat_cnt),  32'd0);
        chk("t1_err",       32'(err_sticky), 32'd0);

        // 2: single beat of two 16s
        in_valid = 1'b1; in_data = {32'd16, 32'd16};
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_l0_count", 32'(out_count), 32'd16);
        chk("t2_l0_lane",  32'(out_lane),  32'd0);
        chk("t2_l0_last",  32'(out_last),  32'd0);
        step();
        @(negedge clk);
        chk("t2_l1_count", 32'(out_count), 32'd16);
        chk("t2_l1_last",  32'(out_last),  32'd1);
        chk("t2_l1_trunc", 32'(out_trunc), 32'd0);
        chk("t2_beat_cnt", 32'(beat_cnt),  32'd1);
        step();
        @(negedge clk);
        chk("t2_drained", 32'(out_valid), 32'd0);

        // 3: back-to-back beats, counts 1..4 with no bubble (beat_cnt is cumulative: 1+2)
        in_valid = 1'b1; in_data = {32'd2, 32'd1};
        step();
        in_data = {32'd4, 32'd3};
        @(negedge clk);
        chk("t3_c1", 32'(out_count), 32'd1);
        step();
        @(negedge clk);
        chk("t3_c2",    32'(out_count), 32'd2);
        chk("t3_ready", 32'(in_ready),  32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_c3",    32'(out_count), 32'd3);
        chk("t3_valid", 32'(out_valid), 32'd1);
        step();
        @(negedge clk);
        chk("t3_c4",    32'(out_count), 32'd4);
        chk("t3_last",  32'(out_last),  32'd1);
        chk("t3_beats", 32'(beat_cnt),  32'd3);
        step();

        // 4: backpressure on lane 0, then a truncated lane 1
        in_valid = 1'b1; in_data = {32'h0001_0005, 32'h0000_FFFF}; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_count", 32'(out_count), 32'h0000_FFFF);
            chk("t4_hold_lane",  32'(out_lane),  32'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_l0_count", 32'(out_count), 32'h0000_FFFF);
        step();
        @(negedge clk);
        chk("t4_l1_count", 32'(out_count), 32'd5);
        chk("t4_l1_trunc", 32'(out_trunc), 32'd1);
        chk("t4_err_pre",  32'(err_sticky), 32'd0);
        step();
        @(negedge clk);
        chk("t4_err_post", 32'(err_sticky), 32'd1);
        chk("t4_idle",     32'(out_valid),  32'd0);

        // Mixed backpressure with a continuously offered beat
        pat = 16'b1011_0010_1101_0110;
        in_valid = 1'b1; in_data = {32'h00FF_0000, 32'h0000_1234};
        for (int i = 0; i < 16; i++) begin
            out_ready = pat[i];
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();

        // 5: reset after lane 0 of {9,8} is taken; lane 1 must never appear
        in_valid = 1'b1; in_data = {32'd9, 32'd8};
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_l0_count", 32'(out_count), 32'd8);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(out_valid),  32'd0);
        chk("t5_beats", 32'(beat_cnt),   32'd0);
        chk("t5_err",   32'(err_sticky), 32'd0);
        step(); step();
        @(negedge clk);
        chk("t5_no_lane9", 32'(saw9), 32'd0);

        // 6: single-lane instance, 65535 back-to-back beats then one more wraps beat_cnt
        rst2 = 1'b0; in_valid2 = 1'b1; in_data2 = 32'h0002_0007;
        repeat (65535) step();
        @(negedge clk);
        chk("t6_beat_ffff", 32'(beat_cnt2),  32'h0000_FFFF);
        chk("t6_last",      32'(out_last2),  32'd1);
        chk("t6_lane",      32'(out_lane2),  32'd0);
        chk("t6_count",     32'(out_count2), 32'd7);
        chk("t6_trunc",     32'(out_trunc2), 32'd1);
        step();
        @(negedge clk);
        chk("t6_beat_wrap", 32'(beat_cnt2),   32'd0);
        chk("t6_err",       32'(err_sticky2), 32'd1);
        in_valid2 = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
